// File: rtl/readout_scan_ctrl.sv
// readout_scan_ctrl: scan sequencer for the READOUT counter datapath. Steps through the
// enabled ring oscillators, times clear/measure windows and presents captured counts.
`default_nettype none

module readout_scan_ctrl #(
   parameter int CNT_W      = 18,
   parameter int CLR_CYCLES = 4,
   parameter int WIN_BASE   = 16,
   parameter int WIN_W      = 12
) (
   input  logic             CLK_REF_IN,
   input  logic             RESET,
   input  logic             START,
   input  logic             CONTINUOUS,
   input  logic [3:0]       CH_MASK,
   input  logic [2:0]       SAMPLE_SEL_CFG,
   input  logic [4:0]       TOTAL_CFG,
   input  logic             STOP,
   input  logic [CNT_W-1:0] CNT_1,
   input  logic [CNT_W-1:0] CNT_2,
   output logic             RO_RESET,
   output logic [1:0]       CLK_RO_SEL,
   output logic [2:0]       SAMPLE_SEL,
   output logic [4:0]       TOTAL,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [1:0]       RES_CH,
   output logic [CNT_W-1:0] RES_CNT_1,
   output logic [CNT_W-1:0] RES_CNT_2,
   output logic             BUSY,
   output logic             OVF
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_MEASURE = 3'd2,
      S_CAPTURE = 3'd3,
      S_PRESENT = 3'd4
   } state_t;

   localparam logic [WIN_W-1:0] CLR_LAST = WIN_W'(CLR_CYCLES - 1);
   localparam logic [WIN_W-1:0] WIN_UNIT = WIN_W'(WIN_BASE);

   state_t           state;
   logic [3:0]       mask_q;
   logic             cont_q;
   logic             stop_pend;
   logic [WIN_W-1:0] timer;

   logic [1:0]       start_ch;
   logic [1:0]       wrap_ch;
   logic [1:0]       next_ch;
   logic             next_found;
   logic [WIN_W-1:0] win_last;
   logic             stop_now;
   logic             end_scan;

   // Lowest set bit of the incoming mask: first channel of a new scan.
   always_comb begin
      start_ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (CH_MASK[i]) start_ch = 2'(i);
      end
   end

   // Next enabled channel above the current one, plus the wrap target.
   always_comb begin
      wrap_ch    = 2'd0;
      next_ch    = 2'd0;
      next_found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i]) begin
            wrap_ch = 2'(i);
            if (i > int'(CLK_RO_SEL)) begin
               next_ch    = 2'(i);
               next_found = 1'b1;
            end
         end
      end
   end

   assign win_last = (WIN_UNIT << SAMPLE_SEL) - WIN_W'(1);
   assign stop_now = stop_pend | STOP;
   assign end_scan = stop_now | (~next_found & ~cont_q);

   always_ff @(posedge CLK_REF_IN) begin
      if (!RESET) begin
         state      <= S_IDLE;
         mask_q     <= 4'd0;
         cont_q     <= 1'b0;
         stop_pend  <= 1'b0;
         timer      <= '0;
         RO_RESET   <= 1'b0;
         CLK_RO_SEL <= 2'd0;
         SAMPLE_SEL <= 3'd0;
         TOTAL      <= 5'd0;
         RES_VALID  <= 1'b0;
         RES_CH     <= 2'd0;
         RES_CNT_1  <= '0;
         RES_CNT_2  <= '0;
         BUSY       <= 1'b0;
         OVF        <= 1'b0;
      end else begin
         if (state != S_IDLE && STOP) stop_pend <= 1'b1;

         case (state)
            S_IDLE: begin
               RO_RESET  <= 1'b0;
               stop_pend <= 1'b0;
               if (START && CH_MASK != 4'd0) begin
                  mask_q     <= CH_MASK;
                  cont_q     <= CONTINUOUS;
                  SAMPLE_SEL <= SAMPLE_SEL_CFG;
                  TOTAL      <= TOTAL_CFG;
                  OVF        <= 1'b0;
                  CLK_RO_SEL <= start_ch;
                  timer      <= CLR_LAST;
                  BUSY       <= 1'b1;
                  state      <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               if (timer == '0) begin
                  RO_RESET <= 1'b1;
                  timer    <= win_last;
                  state    <= S_MEASURE;
               end else begin
                  timer <= timer - WIN_W'(1);
               end
            end

            S_MEASURE: begin
               if (timer == '0) state <= S_CAPTURE;
               else             timer <= timer - WIN_W'(1);
            end

            S_CAPTURE: begin
               RES_CNT_1 <= CNT_1;
               RES_CNT_2 <= CNT_2;
               RES_CH    <= CLK_RO_SEL;
               RES_VALID <= 1'b1;
               if ((&CNT_1) || (&CNT_2)) OVF <= 1'b1;
               state <= S_PRESENT;
            end

            S_PRESENT: begin
               if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  RO_RESET  <= 1'b0;
                  if (end_scan) begin
                     BUSY      <= 1'b0;
                     stop_pend <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     // Single-bit masks land here via wrap_ch and repeat the same channel.
                     CLK_RO_SEL <= next_found ? next_ch : wrap_ch;
                     timer      <= CLR_LAST;
                     state      <= S_CLEAR;
                  end
               end
            end

            default: begin
               RO_RESET  <= 1'b0;
               RES_VALID <= 1'b0;
               BUSY      <= 1'b0;
               stop_pend <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_readout_scan_ctrl.sv
// tb_readout_scan_ctrl: randomized scans checked cycle by cycle against a scan-order and
// timing model derived from the channel mask and window arithmetic.
`timescale 1ns/1ps
`default_nettype none

module tb_readout_scan_ctrl;

   localparam int CNT_W = 18;
   localparam int CLR   = 4;
   localparam int WB    = 16;

   logic             clk = 1'b0;
   logic             RESET = 1'b0;
   logic             START = 1'b0;
   logic             CONTINUOUS = 1'b0;
   logic [3:0]       CH_MASK = 4'd0;
   logic [2:0]       SAMPLE_SEL_CFG = 3'd0;
   logic [4:0]       TOTAL_CFG = 5'd0;
   logic             STOP = 1'b0;
   logic [CNT_W-1:0] CNT_1 = '0;
   logic [CNT_W-1:0] CNT_2 = '0;
   logic             RES_READY = 1'b0;
   logic             RO_RESET;
   logic [1:0]       CLK_RO_SEL;
   logic [2:0]       SAMPLE_SEL;
   logic [4:0]       TOTAL;
   logic             RES_VALID;
   logic [1:0]       RES_CH;
   logic [CNT_W-1:0] RES_CNT_1;
   logic [CNT_W-1:0] RES_CNT_2;
   logic             BUSY;
   logic             OVF;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit force_ones = 1'b0;
   bit m_ovf = 1'b0;
   logic [CNT_W-1:0] hist1 [0:65535];
   logic [CNT_W-1:0] hist2 [0:65535];

   readout_scan_ctrl #(.CNT_W(CNT_W), .CLR_CYCLES(CLR), .WIN_BASE(WB), .WIN_W(12)) dut (
      .CLK_REF_IN(clk), .RESET(RESET), .START(START), .CONTINUOUS(CONTINUOUS),
      .CH_MASK(CH_MASK), .SAMPLE_SEL_CFG(SAMPLE_SEL_CFG), .TOTAL_CFG(TOTAL_CFG), .STOP(STOP),
      .CNT_1(CNT_1), .CNT_2(CNT_2), .RO_RESET(RO_RESET), .CLK_RO_SEL(CLK_RO_SEL),
      .SAMPLE_SEL(SAMPLE_SEL), .TOTAL(TOTAL), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_CH(RES_CH), .RES_CNT_1(RES_CNT_1), .RES_CNT_2(RES_CNT_2), .BUSY(BUSY), .OVF(OVF)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Counter stimulus: the value driven here is the one sampled at edge cyc+1.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         CNT_1 = force_ones ? {CNT_W{1'b1}} : CNT_W'($urandom);
         CNT_2 = CNT_W'($urandom);
         hist1[(cyc + 1) % 65536] = CNT_1;
         hist2[(cyc + 1) % 65536] = CNT_2;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // One full scan from START to IDLE. Expected channel order comes from the mask bits,
   // timing from CLR + (WB << sel) + capture, captured data from the counter history.
   task automatic do_scan(input logic [3:0] mask, input logic [2:0] sel, input logic [4:0] tot,
                          input bit cont, input int n_res, input int stop_at, input int max_hold,
                          input int first_hold, input bit force_first, input bit poke_start);
      int chans[$];
      int idx, seg, d, win, hold, ch;
      bit last;
      logic [CNT_W-1:0] e1, e2;
      logic [14:0] obs_c, exp_c;
      logic [41:0] obs_r, exp_r;
      for (int b = 0; b < 4; b++) if (mask[b]) chans.push_back(b);
      win = WB << sel;
      START = 1'b1; CH_MASK = mask; SAMPLE_SEL_CFG = sel; TOTAL_CFG = tot; CONTINUOUS = cont;
      force_ones = force_first;
      @(posedge clk); #1;
      START = 1'b0; CH_MASK = 4'($urandom); SAMPLE_SEL_CFG = 3'($urandom);
      TOTAL_CFG = 5'($urandom); CONTINUOUS = ~cont;
      m_ovf = 1'b0; seg = cyc; idx = 0;
      for (int r = 0; r < n_res; r++) begin
         ch = chans[idx % chans.size()];
         d = cyc - seg;
         while (d <= CLR + win) begin
            obs_c = {RO_RESET, BUSY, RES_VALID, CLK_RO_SEL, SAMPLE_SEL, TOTAL, OVF};
            exp_c = {(d >= CLR), 1'b1, 1'b0, 2'(ch), sel, tot, m_ovf};
            total++;
            if (obs_c !== exp_c) begin
               bad++;
               $display("FAIL scan_ctrl r=%0d d=%0d got=%h want=%h", r, d, obs_c, exp_c);
            end
            if (stop_at == r && d == 1) STOP = 1'b1;
            else STOP = 1'b0;
            if (poke_start && d == 2) begin
               START = 1'b1; CH_MASK = 4'hF; SAMPLE_SEL_CFG = sel + 3'd1;
            end else begin
               START = 1'b0;
            end
            @(posedge clk); #1;
            d = cyc - seg;
         end
         STOP = 1'b0; START = 1'b0;
         e1 = hist1[cyc % 65536];
         e2 = hist2[cyc % 65536];
         m_ovf = m_ovf | (&e1) | (&e2);
         force_ones = 1'b0;
         exp_r = {1'b1, 2'(ch), e1, e2, m_ovf, 1'b1};
         obs_r = {RES_VALID, RES_CH, RES_CNT_1, RES_CNT_2, OVF, BUSY};
         total++;
         if (obs_r !== exp_r) begin
            bad++;
            $display("FAIL result r=%0d got=%h want=%h", r, obs_r, exp_r);
         end
         hold = (r == 0 && first_hold > 0) ? first_hold : $urandom_range(0, max_hold);
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            obs_r = {RES_VALID, RES_CH, RES_CNT_1, RES_CNT_2, OVF, BUSY};
            total++;
            if (obs_r !== exp_r) begin
               bad++;
               $display("FAIL hold r=%0d h=%0d got=%h want=%h", r, h, obs_r, exp_r);
            end
         end
         RES_READY = 1'b1;
         @(posedge clk); #1;
         RES_READY = 1'b0;
         last = (r == stop_at) || (!cont && idx + 1 >= chans.size());
         if (last) begin
            total++;
            if ({BUSY, RES_VALID, RO_RESET} !== 3'b000) begin
               bad++;
               $display("FAIL end_idle got busy/valid/ro=%b want=000", {BUSY, RES_VALID, RO_RESET});
            end
            break;
         end
         idx++;
         seg = cyc;
      end
   endtask

   task automatic test_reset();
      logic [51:0] obs;
      RESET = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      obs = {RO_RESET, CLK_RO_SEL, SAMPLE_SEL, TOTAL, RES_VALID, RES_CH, RES_CNT_1, RES_CNT_2, BUSY, OVF};
      total++;
      if (obs !== 52'd0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0", obs);
      end
      RESET = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({BUSY, RES_VALID} !== 2'b00) begin
         bad++;
         $display("FAIL reset_release got=%b want=00", {BUSY, RES_VALID});
      end
   endtask

   task automatic test_single();
      do_scan(4'b0001, 3'd2, 5'd9, 1'b0, 1, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_two_ch();
      do_scan(4'b1010, 3'd0, 5'd17, 1'b0, 2, -1, 2, 0, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      do_scan(4'b0101, 3'd0, 5'd3, 1'b1, 5, 4, 3, 20, 1'b0, 1'b0);
   endtask

   task automatic test_ovf();
      do_scan(4'b0011, 3'd0, 5'd1, 1'b0, 2, -1, 1, 0, 1'b1, 1'b0);
      do_scan(4'b0001, 3'd0, 5'd1, 1'b0, 1, -1, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [51:0] obs;
      START = 1'b1; CH_MASK = 4'b0100; SAMPLE_SEL_CFG = 3'd1; TOTAL_CFG = 5'd7; CONTINUOUS = 1'b0;
      @(posedge clk); #1;
      START = 1'b0;
      repeat (CLR + 5) @(posedge clk);
      #1;
      total++;
      if ({BUSY, CLK_RO_SEL, RO_RESET} !== 4'b1_10_1) begin
         bad++;
         $display("FAIL mid_measure got=%b want=1101", {BUSY, CLK_RO_SEL, RO_RESET});
      end
      RESET = 1'b0;
      @(posedge clk); #1;
      obs = {RO_RESET, CLK_RO_SEL, SAMPLE_SEL, TOTAL, RES_VALID, RES_CH, RES_CNT_1, RES_CNT_2, BUSY, OVF};
      total++;
      if (obs !== 52'd0) begin
         bad++;
         $display("FAIL mid_reset got=%h want=0", obs);
      end
      RESET = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         total++;
         if ({BUSY, RES_VALID} !== 2'b00) begin
            bad++;
            $display("FAIL after_reset got=%b want=00", {BUSY, RES_VALID});
         end
      end
      do_scan(4'b0101, 3'd0, 5'd2, 1'b0, 2, -1, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_ignore();
      STOP = 1'b1;
      @(posedge clk); #1;
      STOP = 1'b0; START = 1'b1; CH_MASK = 4'b0000;
      @(posedge clk); #1;
      START = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         total++;
         if ({BUSY, RES_VALID, RO_RESET} !== 3'b000) begin
            bad++;
            $display("FAIL ignore_idle got=%b want=000", {BUSY, RES_VALID, RO_RESET});
         end
      end
      do_scan(4'b0110, 3'd1, 5'd21, 1'b0, 2, -1, 2, 0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [3:0] mask;
      bit cont;
      int n;
      for (int it = 0; it < 8; it++) begin
         mask = 4'($urandom_range(1, 15));
         cont = 1'($urandom);
         n = cont ? $urandom_range(1, 6) : $countones(mask);
         do_scan(mask, 3'($urandom_range(0, 3)), 5'($urandom), cont, n,
                 cont ? n - 1 : -1, 3, 0, 1'($urandom_range(0, 3) == 0), 1'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_ch();
      test_backpressure();
      test_ovf();
      test_reset_mid();
      test_ignore();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
